// File: rtl/traffic_phase_sched.sv
// Two-road traffic light phase scheduler with pedestrian shortening and manual stepping.
// Optional all-red clearance phase enabled by defining TRAFFIC_ALL_RED_EN.
module traffic_phase_sched #(
    parameter int unsigned GREEN_T  = 8,
    parameter int unsigned YELLOW_T = 2,
    parameter int unsigned PED_MIN  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ped_req,
    input  logic       manual,
    input  logic       step,
    output logic [2:0] A,
    output logic [2:0] B,
    output logic [7:0] count,
    output logic [2:0] phase,
    output logic       ped_ack
);

    localparam logic [7:0] GREEN_C  = 8'(GREEN_T);
    localparam logic [7:0] YELLOW_C = 8'(YELLOW_T);
    localparam logic [7:0] PED_C    = 8'(PED_MIN);

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    typedef enum logic [2:0] {
        ST_AG = 3'd0,
        ST_AY = 3'd1,
        ST_BG = 3'd2,
        ST_BY = 3'd3,
        ST_AR = 3'd4
    } state_t;

    state_t     state_q, state_d, state_nxt;
    logic [7:0] count_q, count_d;
    logic       latch_q, latch_d;
    logic       ack_q, ack_d;
    logic       legal;
    logic       advance;
`ifdef TRAFFIC_ALL_RED_EN
    // Remembers which yellow preceded the all-red phase (1 = road B yellow).
    logic       side_q, side_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_AG;
            count_q <= GREEN_C;
            latch_q <= 1'b0;
            ack_q   <= 1'b0;
`ifdef TRAFFIC_ALL_RED_EN
            side_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            latch_q <= latch_d;
            ack_q   <= ack_d;
`ifdef TRAFFIC_ALL_RED_EN
            side_q  <= side_d;
`endif
        end
    end

    // Successor phase, used by both the timed and the manual advance.
    always_comb begin
        state_nxt = ST_AG;
`ifdef TRAFFIC_ALL_RED_EN
        side_d    = side_q;
`endif
        case (state_q)
            ST_AG: state_nxt = ST_AY;
`ifdef TRAFFIC_ALL_RED_EN
            ST_AY: begin
                state_nxt = ST_AR;
                if (advance) side_d = 1'b0;
            end
            ST_BY: begin
                state_nxt = ST_AR;
                if (advance) side_d = 1'b1;
            end
            ST_AR: state_nxt = side_q ? ST_AG : ST_BG;
`else
            ST_AY: state_nxt = ST_BG;
            ST_BY: state_nxt = ST_AG;
`endif
            ST_BG: state_nxt = ST_BY;
            default: state_nxt = ST_AG;
        endcase
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        latch_d = latch_q | ped_req;
        ack_d   = 1'b0;
        advance = 1'b0;

        case (state_q)
            ST_AG, ST_AY, ST_BG, ST_BY: legal = 1'b1;
`ifdef TRAFFIC_ALL_RED_EN
            ST_AR:                      legal = 1'b1;
`endif
            default:                    legal = 1'b0;
        endcase

        if (!legal) begin
            state_d = ST_AG;
            count_d = GREEN_C;
        end else if (manual) begin
            advance = step;
        end else if (tick) begin
            // Shortening looks at the latch as it stood before this cycle's request.
            if (count_q <= 8'd1) begin
                advance = 1'b1;
            end else if (state_q == ST_AG && latch_q && count_q > PED_C) begin
                count_d = PED_C;
            end else begin
                count_d = count_q - 8'd1;
            end
        end

        if (advance) begin
            state_d = state_nxt;
            case (state_nxt)
                ST_AG, ST_BG: count_d = GREEN_C;
                ST_AY, ST_BY: count_d = YELLOW_C;
                default:      count_d = 8'd1;
            endcase
            if (state_nxt == ST_BG && latch_q) begin
                ack_d   = 1'b1;
                latch_d = ped_req;
            end
        end
    end

    // Lamp decode straight from the state register.
    always_comb begin
        A = LAMP_R;
        B = LAMP_R;
        case (state_q)
            ST_AG: A = LAMP_G;
            ST_AY: A = LAMP_Y;
            ST_BG: B = LAMP_G;
            ST_BY: B = LAMP_Y;
            default: ;
        endcase
    end

    assign phase   = 3'(state_q);
    assign count   = count_q;
    assign ped_ack = ack_q;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Directed self-checking bench for traffic_phase_sched (default parameters).
// Expectations follow TRAFFIC_ALL_RED_EN when it is defined for the build.
module tb_traffic_phase_sched;

`ifdef TRAFFIC_ALL_RED_EN
    localparam int AR_X = 1;
`else
    localparam int AR_X = 0;
`endif

    logic       clk = 1'b0;
    logic       rst, tick, ped_req, manual, step;
    logic [2:0] A, B, phase;
    logic [7:0] count;
    logic       ped_ack;

    int errors = 0;
    int checks = 0;

    traffic_phase_sched dut (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .ped_req(ped_req),
        .manual (manual),
        .step   (step),
        .A      (A),
        .B      (B),
        .count  (count),
        .phase  (phase),
        .ped_ack(ped_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] lamps(input logic [2:0] ph);
        case (ph)
            3'd0:    lamps = {3'b001, 3'b100};
            3'd1:    lamps = {3'b010, 3'b100};
            3'd2:    lamps = {3'b100, 3'b001};
            3'd3:    lamps = {3'b100, 3'b010};
            default: lamps = {3'b100, 3'b100};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input int ph, input int cnt, input logic ack);
        chk({tag, "_phase"}, 32'(phase), 32'(ph));
        chk({tag, "_count"}, 32'(count), 32'(cnt));
        chk({tag, "_lamps"}, 32'({A, B}), 32'(lamps(3'(ph))));
        chk({tag, "_ack"},   32'(ped_ack), 32'(ack));
    endtask

    // One clock: inputs applied on the falling edge, outputs sampled 1ns after the rising edge.
    task automatic cyc(input logic t, input logic p, input logic s);
        @(negedge clk);
        tick    = t;
        ped_req = p;
        step    = s;
        @(posedge clk);
        #1;
        tick    = 1'b0;
        ped_req = 1'b0;
        step    = 1'b0;
    endtask

    task automatic adv(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int ep, ec;
        rst = 1'b1; tick = 1'b0; ped_req = 1'b0; manual = 1'b0; step = 1'b0;
        #2;
        chk_st("reset", 0, 8, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Full automatic cycle from reset.
        for (int k = 1; k <= 20 + 2 * AR_X; k++) begin
            cyc(1'b1, 1'b0, 1'b0);
`ifdef TRAFFIC_ALL_RED_EN
            if      (k < 8)   begin ep = 0; ec = 8 - k;  end
            else if (k < 10)  begin ep = 1; ec = 10 - k; end
            else if (k == 10) begin ep = 4; ec = 1;      end
            else if (k < 19)  begin ep = 2; ec = 19 - k; end
            else if (k < 21)  begin ep = 3; ec = 21 - k; end
            else if (k == 21) begin ep = 4; ec = 1;      end
            else              begin ep = 0; ec = 8;      end
`else
            if      (k < 8)  begin ep = 0; ec = 8 - k;  end
            else if (k < 10) begin ep = 1; ec = 10 - k; end
            else if (k < 18) begin ep = 2; ec = 18 - k; end
            else if (k < 20) begin ep = 3; ec = 20 - k; end
            else             begin ep = 0; ec = 8;      end
`endif
            chk_st($sformatf("auto_k%0d", k), ep, ec, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b0);
        chk_st("no_tick_hold", 0, 8, 1'b0);

        // Pedestrian request at count 7 shortens green to PED_MIN.
        cyc(1'b1, 1'b0, 1'b0);
        chk_st("ped_pre", 0, 7, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk_st("ped_latch", 0, 7, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk_st("ped_short", 0, 3, 1'b0);
        adv(2);
        chk_st("ped_ag1", 0, 1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk_st("ped_ay", 1, 2, 1'b0);
        adv(1 + AR_X);
        cyc(1'b1, 1'b0, 1'b0);
        chk_st("ped_bg_ack", 2, 8, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk_st("ped_ack_drop", 2, 8, 1'b0);
        adv(10 + AR_X);
        chk_st("ped_back_ag", 0, 8, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk_st("latch_cleared", 0, 7, 1'b0);

        // Request coincident with tick: old latch used, shortening next tick.
        cyc(1'b1, 1'b1, 1'b0);
        chk_st("same_cycle", 0, 6, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk_st("same_next", 0, 3, 1'b0);
        adv(3 + AR_X + 2);
        chk_st("same_bg_ack", 2, 8, 1'b1);

        // Request late in green (count 2): normal decrement.
        adv(10 + AR_X);
        adv(6);
        chk_st("late_ag2", 0, 2, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk_st("late_ag1", 0, 1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk_st("late_ay", 1, 2, 1'b0);
        adv(1 + AR_X);
        cyc(1'b1, 1'b0, 1'b0);
        chk_st("late_bg_ack", 2, 8, 1'b1);

        // Manual stepping from BG at count 5.
        adv(3);
        chk_st("man_bg5", 2, 5, 1'b0);
        manual = 1'b1;
        adv(10);
        chk_st("man_hold", 2, 5, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk_st("man_by", 3, 2, 1'b0);
        if (AR_X != 0) begin
            cyc(1'b0, 1'b0, 1'b1);
            chk_st("man_ar", 4, 1, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b1);
        chk_st("man_ag", 0, 8, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk_st("man_ay", 1, 2, 1'b0);
        manual = 1'b0;
        cyc(1'b0, 1'b0, 1'b1);
        chk_st("step_ignored", 1, 2, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk_st("man_resume", 1, 1, 1'b0);

        // Asynchronous reset mid-BY with a pending request.
        adv(1 + AR_X + 8);
        chk_st("rst_pre_by", 3, 2, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk_st("rst_async", 0, 8, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0);
        chk_st("rst_latch_gone", 0, 7, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
